// File: rtl/seg_display_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter_pkg
// Shared definitions for the seven-segment display arbiter:
//   state_e            - FSM state encoding (IDLE / HOLD)
//   DISP_W             - width of one display word (four hex digits)
//   BOARD_HOLD_CYCLES  - owner tenure for the 50 MHz board (100 ms)
//   SIM_HOLD_CYCLES    - short tenure used by benches
//   hold_fits()        - true when a tenure is >= 1 and its load value fits
// -----------------------------------------------------------------------------
package seg_display_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int          DISP_W            = 16;
  localparam int unsigned BOARD_HOLD_CYCLES = 32'd5_000_000;
  localparam int unsigned SIM_HOLD_CYCLES   = 32'd4;

  // The counter is loaded with cycles-1, so that value must fit in 'width' bits.
  function automatic bit hold_fits(input int unsigned cycles, input int width);
    longint unsigned load;
    load = longint'(cycles) - 64'd1;
    if (cycles == 0) return 1'b0;
    if (width >= 63) return 1'b1;
    return load < (64'd1 << width);
  endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority picker. Searches req starting at
// index ptr and wrapping from NREQ-1 back to 0; the first set bit wins.
//   req   [NREQ-1:0]  request vector
//   ptr   [OWN_W-1:0] highest-priority index for this search (must be < NREQ)
//   idx   [OWN_W-1:0] winning index (0 when nothing is requested)
//   valid             at least one request is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int OWN_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [OWN_W-1:0] ptr,
  output logic [OWN_W-1:0] idx,
  output logic             valid
);

  // Walk the offsets from farthest to nearest so the nearest set bit to ptr
  // is the last one written and therefore the winner.
  always_comb begin
    int j;
    // NOTE: every output gets a default before any conditional write, so no
    // path through the block leaves a value unassigned and no latch is inferred.
    idx   = '0;
    valid = |req;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) idx = OWN_W'(j);
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares one 4-digit seven-segment display between NREQ requesters. The display
// is granted round-robin and each owner keeps it for HOLD_CYCLES clocks so the
// value stays readable. While an owner holds the display its word is re-sampled
// every cycle, so a live value tracks its source with one cycle of latency.
//   clk          system clock, all state on posedge
//   rst_n        synchronous active-low reset
//   req          per-requester level request
//   data         requester i's word at data[16*i +: 16]
//   lock         freeze the current owner across tenure expiries
//   disp_d       word to the segment driver's multiplexer
//   owner        index of the current owner
//   owner_valid  high while the display is held (HOLD state)
//   done         one-cycle pulse on bit i when owner i's tenure expires
// -----------------------------------------------------------------------------
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter int          OWN_W       = 2,
  parameter int          HOLD_W      = 24,
  parameter int unsigned HOLD_CYCLES = BOARD_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [DISP_W*NREQ-1:0]   data,
  input  logic                     lock,
  output logic [DISP_W-1:0]        disp_d,
  output logic [OWN_W-1:0]         owner,
  output logic                     owner_valid,
  output logic [NREQ-1:0]          done
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam bit                CFG_OK    = hold_fits(HOLD_CYCLES, HOLD_W);

  state_e              state_q, state_d;
  logic [OWN_W-1:0]    owner_q, owner_d;
  logic [OWN_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]   count_q, count_d;
  logic [DISP_W-1:0]   disp_word_q, disp_word_d;
  logic [NREQ-1:0]     done_q, done_d;

  logic [OWN_W-1:0]    pick_idx;
  logic                pick_valid;
  logic [DISP_W-1:0]   lane [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane[i] = data[i*DISP_W +: DISP_W];
  end

  rr_pick #(
    .NREQ  (NREQ),
    .OWN_W (OWN_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  function automatic logic [OWN_W-1:0] ptr_after(input logic [OWN_W-1:0] idx);
    return (idx == OWN_W'(NREQ - 1)) ? '0 : idx + OWN_W'(1);
  endfunction

  always_comb begin
    logic grant;
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    count_d     = count_q;
    disp_word_d = disp_word_q;
    done_d      = '0;
    grant       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) grant = 1'b1;
      end
      ST_HOLD: begin
        if (!req[owner_q]) begin
          // Early release wins over a coincident expiry: no done pulse, and
          // the display keeps the departing owner's last word if nobody else
          // is waiting.
          if (pick_valid) grant = 1'b1;
          else            state_d = ST_IDLE;
        end else if (count_q == '0) begin
          done_d[owner_q] = 1'b1;
          if (lock) begin
            count_d     = HOLD_LOAD;
            disp_word_d = lane[owner_q];
          end else if (pick_valid) begin
            grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d     = count_q - HOLD_W'(1);
          disp_word_d = lane[owner_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d     = ST_HOLD;
      owner_d     = pick_idx;
      rr_ptr_d    = ptr_after(pick_idx);
      count_d     = HOLD_LOAD;
      disp_word_d = lane[pick_idx];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge like any other input; aborting a
    // tenure this way clears done_q too, so no stale pulse survives reset.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      disp_word_q <= '0;
      done_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the old
      // values of its neighbours, matching flip-flop behaviour.
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      disp_word_q <= disp_word_d;
      done_q      <= done_d;
    end
  end

  // Simulation-only configuration check: a tenure of zero or one whose load
  // value overflows the counter would silently shorten every tenure.
  always @(posedge clk) begin
    assert (CFG_OK) else $error("seg_display_arbiter: HOLD_CYCLES does not fit HOLD_W");
  end

  assign disp_d      = disp_word_q;
  assign owner       = owner_q;
  assign owner_valid = (state_q == ST_HOLD);
  assign done        = done_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
module tb_seg_display_arbiter;
  import seg_display_arbiter_pkg::*;

  localparam int NREQ   = 4;
  localparam int OWN_W  = 2;
  localparam int HOLD_W = 24;

  typedef struct packed {
    logic [15:0] disp;
    logic [1:0]  owner;
    logic        valid;
    logic [3:0]  done;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b1111;
  logic        lock = 1'b0;
  logic [15:0] d0 = 16'hA000, d1 = 16'hA111, d2 = 16'hBEEF, d3 = 16'hA333;
  logic [63:0] data;
  logic [15:0] disp_d;
  logic [1:0]  owner;
  logic        owner_valid;
  logic [3:0]  done;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  assign data = {d3, d2, d1, d0};

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .NREQ        (NREQ),
    .OWN_W       (OWN_W),
    .HOLD_W      (HOLD_W),
    .HOLD_CYCLES (SIM_HOLD_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .data        (data),
    .lock        (lock),
    .disp_d      (disp_d),
    .owner       (owner),
    .owner_valid (owner_valid),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the outputs expected after the next edge, clock once, then pop and
  // compare against what the DUT shows 1 ns after that edge.
  task automatic step(input string tag, input logic [15:0] d, input logic [1:0] o,
                      input logic v, input logic [3:0] dn);
    exp_t e;
    sb_q.push_back('{disp: d, owner: o, valid: v, done: dn});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".disp"},  32'(disp_d),      32'(e.disp));
    check({tag, ".owner"}, 32'(owner),       32'(e.owner));
    check({tag, ".valid"}, 32'(owner_valid), 32'(e.valid));
    check({tag, ".done"},  32'(done),        32'(e.done));
  endtask

  // One full tenure: done of the previous owner shows on the first cycle.
  task automatic tenure(input string tag, input logic [15:0] d, input logic [1:0] o,
                        input logic [3:0] dn_first);
    step(tag, d, o, 1'b1, dn_first);
    repeat (3) step(tag, d, o, 1'b1, 4'b0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles with every requester active.
    repeat (3) step("reset", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    step("first_grant", 16'hA000, 2'd0, 1'b1, 4'b0000);

    // Single requester, live-value tracking.
    rst_n = 1'b0;
    step("reset2", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0100;
    tenure("single1", 16'hBEEF, 2'd2, 4'b0000);
    step("single_exp", 16'hBEEF, 2'd2, 1'b1, 4'b0100);
    d2 = 16'h1234;
    repeat (3) step("single_track", 16'h1234, 2'd2, 1'b1, 4'b0000);
    step("single_exp2", 16'h1234, 2'd2, 1'b1, 4'b0100);

    // Rotation over requesters 0, 1, 3.
    rst_n = 1'b0;
    step("reset3", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b1011;
    tenure("rot0", 16'hA000, 2'd0, 4'b0000);
    tenure("rot1", 16'hA111, 2'd1, 4'b0001);
    tenure("rot3", 16'hA333, 2'd3, 4'b0010);
    step("rot0b", 16'hA000, 2'd0, 1'b1, 4'b1000);

    // Lock keeps owner 1 across three expiries.
    rst_n = 1'b0;
    step("reset4", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b0011;
    tenure("lock_o0", 16'hA000, 2'd0, 4'b0000);
    tenure("lock_o1", 16'hA111, 2'd1, 4'b0001);
    lock = 1'b1;
    tenure("locked1", 16'hA111, 2'd1, 4'b0010);
    tenure("locked2", 16'hA111, 2'd1, 4'b0010);
    tenure("locked3", 16'hA111, 2'd1, 4'b0010);
    lock = 1'b0;
    step("unlock", 16'hA000, 2'd0, 1'b1, 4'b0010);

    // Early release of owner 3 with requester 0 waiting.
    rst_n = 1'b0;
    step("reset5", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b1000;
    step("er_grant", 16'hA333, 2'd3, 1'b1, 4'b0000);
    step("er_cnt2", 16'hA333, 2'd3, 1'b1, 4'b0000);
    req = 4'b0001;
    step("er_regrant", 16'hA000, 2'd0, 1'b1, 4'b0000);

    // Early release of owner 3 with nobody waiting.
    rst_n = 1'b0;
    step("reset6", 16'h0000, 2'd0, 1'b0, 4'b0000);
    rst_n = 1'b1;
    req   = 4'b1000;
    step("er2_grant", 16'hA333, 2'd3, 1'b1, 4'b0000);
    step("er2_cnt2", 16'hA333, 2'd3, 1'b1, 4'b0000);
    req = 4'b0000;
    step("er2_idle", 16'hA333, 2'd3, 1'b0, 4'b0000);
    step("er2_hold", 16'hA333, 2'd3, 1'b0, 4'b0000);

    // Reset in the middle of a tenure (count == 1).
    req = 4'b0100;
    step("mid_grant", 16'h1234, 2'd2, 1'b1, 4'b0000);
    step("mid_cnt2", 16'h1234, 2'd2, 1'b1, 4'b0000);
    step("mid_cnt1", 16'h1234, 2'd2, 1'b1, 4'b0000);
    rst_n = 1'b0;
    step("mid_reset", 16'h0000, 2'd0, 1'b0, 4'b0000);
    step("mid_reset2", 16'h0000, 2'd0, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
